// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the UART transmitter FIFO-read port among
// N_CH FWFT byte-stream requesters, optionally prefixing each packet with {HDR_TAG, channel}.
module uart_tx_arbiter #(
    parameter int          N_CH    = 4,
    parameter logic [3:0]  HDR_TAG = 4'hA,
    parameter bit          ADD_HDR = 1'b1,
    parameter int          MAX_PKT = 64
) (
    input  logic                clk_10MGz,
    input  logic                rst,
    input  logic [N_CH-1:0]     req_empty,
    input  logic [N_CH*8-1:0]   req_rdata,
    input  logic [N_CH-1:0]     req_last,
    output logic [N_CH-1:0]     req_re,
    input  logic [N_CH-1:0]     ch_enable,
    output logic                empty,
    output logic [7:0]          rdata,
    input  logic                re,
    output logic [3:0]          grant_id,
    output logic                busy,
    output logic                underrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state_r;
    logic [3:0]      grant_id_r;
    logic [3:0]      last_grant_r;
    logic [7:0]      byte_cnt_r;
    logic [7:0]      rdata_r;
    logic            underrun_r;

    logic [N_CH-1:0] cand_s;
    logic            found_s;
    logic [3:0]      winner_s;
    logic            cur_empty_s;
    logic            cur_last_s;
    logic [7:0]      cur_rdata_s;
    logic            empty_s;
    logic            accept_s;
    logic [N_CH-1:0] req_re_s;

    // Round-robin scan starting just after the previous winner
    always_comb begin
        cand_s   = ~req_empty & ch_enable;
        found_s  = 1'b0;
        winner_s = 4'd0;
        for (int i = 1; i <= N_CH; i++) begin
            int idx;
            idx = (int'(last_grant_r) + i) % N_CH;
            if (!found_s && cand_s[idx]) begin
                found_s  = 1'b1;
                winner_s = 4'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Select the granted channel's FIFO view and generate its pop strobe
    always_comb begin
        cur_empty_s = 1'b1;
        cur_last_s  = 1'b0;
        cur_rdata_s = 8'h00;
        req_re_s    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_id_r == 4'(i)) begin
                cur_empty_s = req_empty[i];
                cur_last_s  = req_last[i];
                cur_rdata_s = req_rdata[8*i +: 8];
                req_re_s[i] = (state_r == ST_DATA) & re & ~req_empty[i];
            end else begin
                req_re_s[i] = 1'b0;
            end
        end
    end

    // UART-side empty flag depends on where we are in the packet
    always_comb begin
        case (state_r)
            ST_IDLE: empty_s = 1'b1;
            ST_HDR:  empty_s = 1'b0;
            ST_DATA: empty_s = cur_empty_s;
            default: empty_s = 1'b1;
        endcase
        accept_s = re & ~empty_s;
    end

    // Packet FSM with registered UART data, grant and underrun pulse
    always_ff @(posedge clk_10MGz or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= 4'd0;
            last_grant_r <= 4'(N_CH - 1);
            byte_cnt_r   <= 8'd0;
            rdata_r      <= 8'h00;
            underrun_r   <= 1'b0;
        end else begin
            underrun_r <= re & empty_s;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r   <= winner_s;
                        last_grant_r <= winner_s;
                        byte_cnt_r   <= 8'd0;
                        state_r      <= ADD_HDR ? ST_HDR : ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        rdata_r <= {HDR_TAG, grant_id_r};
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        rdata_r    <= cur_rdata_s;
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                        // Starvation guard: cut the packet after MAX_PKT bytes
                        if (cur_last_s || (byte_cnt_r == 8'(MAX_PKT - 1))) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign req_re   = req_re_s;
    assign empty    = empty_s;
    assign rdata    = rdata_r;
    assign grant_id = grant_id_r;
    assign busy     = (state_r != ST_IDLE);
    assign underrun = underrun_r;

endmodule
